full_adder: RTL and testbench



---
 rtl/full_adder.sv | 178 +++++++++++++++++
 tb/tb_full_adder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Single-bit full adder cell with a registered copy of its result and a
// built-in self-test engine. The BIST drives all eight input combinations
// through a second, private copy of the adder equations and counts how many
// results disagree with an arithmetic reference (the popcount of the
// applied vector).
//
// Ports
//   clk         in   rising-edge clock for the registered path and the BIST
//   rst         in   asynchronous, active-high reset
//   a, b, cin   in   external adder operands
//   s, cout     out  combinational sum / carry of a, b, cin
//   s_q, cout_q out  s / cout registered on every rising edge of clk
//   bist_start  in   level sampled on rising clk; starts a sweep from IDLE/DONE
//   bist_busy   out  high while the sweep is running
//   bist_done   out  high once a sweep completes, held until restart or reset
//   bist_pass   out  bist_done with zero mismatches
//   bist_errs   out  mismatch count of the last sweep (0..8)
//   bist_vec    out  vector currently applied to the internal adder copy
//
// Handshake: bist_start is a plain level, not a valid/ready pair. It is only
// acted on in IDLE or DONE; while busy it is ignored, so holding it high gives
// back-to-back sweeps separated by one DONE cycle.
// -----------------------------------------------------------------------------
module full_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       s,
    output logic       cout,
    output logic       s_q,
    output logic       cout_q,
    input  logic       bist_start,
    output logic       bist_busy,
    output logic       bist_done,
    output logic       bist_pass,
    output logic [3:0] bist_errs,
    output logic [2:0] bist_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    localparam logic [3:0] ERRS_MAX = 4'd8;

    // Shared adder equations; each use below is an independent copy of logic.
    function automatic logic [1:0] fa_eval(input logic x, input logic y, input logic z);
        logic sum_bit;
        logic carry_bit;
        sum_bit   = x ^ y ^ z;
        carry_bit = (x & y) | (x & z) | (y & z);
        return {carry_bit, sum_bit};
    endfunction

    // ------------------------------------------------------------------
    // External datapath: purely combinational, independent of rst/BIST
    // ------------------------------------------------------------------
    always_comb begin
        {cout, s} = fa_eval(a, b, cin);
    end

    // ------------------------------------------------------------------
    // Registered copy of the external result (no enable)
    // ------------------------------------------------------------------
    logic s_d;
    logic cout_d;
    logic s_q_r;
    logic cout_q_r;

    always_comb begin
        s_d    = s;
        cout_d = cout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q_r    <= 1'b0;
            cout_q_r <= 1'b0;
        end else begin
            s_q_r    <= s_d;
            cout_q_r <= cout_d;
        end
    end

    assign s_q    = s_q_r;
    assign cout_q = cout_q_r;

    // ------------------------------------------------------------------
    // BIST: private adder copy fed only from the sweep vector
    // ------------------------------------------------------------------
    bist_state_e state_q;
    bist_state_e state_d;
    logic [2:0]  vec_q;
    logic [2:0]  vec_d;
    logic [3:0]  errs_q;
    logic [3:0]  errs_d;

    logic        a_i;
    logic        b_i;
    logic        cin_i;
    logic        s_i;
    logic        cout_i;
    logic [1:0]  core_res;
    logic [1:0]  exp_res;

    always_comb begin
        {a_i, b_i, cin_i} = vec_q;
        {cout_i, s_i}     = fa_eval(a_i, b_i, cin_i);
        core_res          = {cout_i, s_i};
    end

    // Reference is arithmetic (count of ones), deliberately not the same
    // xor/majority form as the core, so a broken core cannot agree with it.
    always_comb begin
        exp_res = {1'b0, vec_q[0]} + {1'b0, vec_q[1]} + {1'b0, vec_q[2]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            errs_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            errs_q  <= errs_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        errs_d  = errs_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    state_d = ST_RUN;
                    vec_d   = 3'd0;
                    errs_d  = 4'd0;
                end
            end
            ST_RUN: begin
                if ((core_res != exp_res) && (errs_q != ERRS_MAX)) begin
                    errs_d = errs_q + 4'd1;
                end
                // vec wraps 7 -> 0 on the last RUN edge; DONE ignores it.
                vec_d = vec_q + 3'd1;
                if (vec_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = 3'd0;
                errs_d  = 4'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bist_busy = (state_q == ST_RUN);
        bist_done = (state_q == ST_DONE);
        bist_pass = (state_q == ST_DONE) && (errs_q == 4'd0);
        bist_errs = errs_q;
        bist_vec  = vec_q;
    end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Randomised, self-checking bench for full_adder. Expected values come from
// plain arithmetic (a + b + cin) and from a sweep-phase model of the BIST
// (edges elapsed since start was sampled).
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       cin;
    logic       s;
    logic       cout;
    logic       s_q;
    logic       cout_q;
    logic       bist_start;
    logic       bist_busy;
    logic       bist_done;
    logic       bist_pass;
    logic [3:0] bist_errs;
    logic [2:0] bist_vec;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];

    full_adder dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .s          (s),
        .cout       (cout),
        .s_q        (s_q),
        .cout_q     (cout_q),
        .bist_start (bist_start),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_pass  (bist_pass),
        .bist_errs  (bist_errs),
        .bist_vec   (bist_vec)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference models ----------------
    function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
        int total;
        total = int'(x) + int'(y) + int'(z);
        return total[1:0];
    endfunction

    // m = number of rising edges since the edge that sampled bist_start.
    // Returns {busy, done, pass, errs} for a healthy sweep.
    function automatic logic [6:0] ref_bist(input int m);
        if (m >= 1 && m <= 8) return {1'b1, 1'b0, 1'b0, 4'd0};
        return {1'b0, 1'b1, 1'b1, 4'd0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        a   = 1'($urandom_range(0, 1));
        b   = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bist_start = 1'b0;
        a = 1'b1; b = 1'b0; cin = 1'b0;
        tick();
        tick();
        checks++;
        if ({s_q, cout_q, bist_busy, bist_done, bist_pass, bist_errs, bist_vec} !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: got s_q=%b cout_q=%b busy=%b done=%b pass=%b errs=%0d vec=%0d, want all 0",
                     s_q, cout_q, bist_busy, bist_done, bist_pass, bist_errs, bist_vec);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_comb_exhaustive();
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            {a, b, cin} = vv;
            #10;
            checks++;
            if ({cout, s} !== ref_add(vv[2], vv[1], vv[0])) begin
                errors++;
                $display("FAIL comb_exhaustive[%0d]: got {cout,s}=%b, want %b", v, {cout, s}, ref_add(vv[2], vv[1], vv[0]));
            end
        end
    endtask

    task automatic test_comb_random();
        for (int i = 0; i < 16; i++) begin
            drive_random();
            #3;
            checks++;
            if ({cout, s} !== ref_add(a, b, cin)) begin
                errors++;
                $display("FAIL comb_random[%0d]: abc=%b%b%b got {cout,s}=%b, want %b", i, a, b, cin, {cout, s}, ref_add(a, b, cin));
            end
        end
    endtask

    task automatic test_registered();
        tick();
        // Latency: with 1,1,0 applied before edge k, s_q/cout_q change only after it.
        a = 1'b0; b = 1'b0; cin = 1'b0;
        tick();
        a = 1'b1; b = 1'b1; cin = 1'b0;
        #2;
        checks++;
        if ({cout_q, s_q} !== 2'b00) begin
            errors++;
            $display("FAIL reg_before_edge: got {cout_q,s_q}=%b, want 00", {cout_q, s_q});
        end
        tick();
        checks++;
        if ({cout_q, s_q} !== 2'b10) begin
            errors++;
            $display("FAIL reg_after_edge: got {cout_q,s_q}=%b, want 10", {cout_q, s_q});
        end
        // Random stream through the expected queue.
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            drive_random();
            exp_q.push_back(ref_add(a, b, cin));
            tick();
            begin
                logic [1:0] want;
                want = exp_q.pop_front();
                checks++;
                if ({cout_q, s_q} !== want) begin
                    errors++;
                    $display("FAIL reg_stream[%0d]: got {cout_q,s_q}=%b, want %b", i, {cout_q, s_q}, want);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        a = 1'b1; b = 1'b0; cin = 1'b0;
        tick();
        checks++;
        if (s_q !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_pre: got s_q=%b, want 1", s_q);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_q, cout_q, bist_busy, bist_done, bist_errs} !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_now: got s_q=%b cout_q=%b busy=%b done=%b errs=%0d, want all 0",
                     s_q, cout_q, bist_busy, bist_done, bist_errs);
        end
        a = 1'b1; b = 1'b1; cin = 1'b1;
        #1;
        checks++;
        if ({cout, s} !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_comb: got {cout,s}=%b, want 11", {cout, s});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bist_nominal();
        bist_start = 1'b1;
        tick();                       // start sampled here (m = 0 -> 1)
        bist_start = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            checks++;
            if ({bist_busy, bist_done, bist_pass, bist_errs} !== ref_bist(m)) begin
                errors++;
                $display("FAIL bist_nominal[m=%0d]: got busy/done/pass/errs=%b, want %b",
                         m, {bist_busy, bist_done, bist_pass, bist_errs}, ref_bist(m));
            end
            if (m <= 8) begin
                checks++;
                if (bist_vec !== 3'(m - 1)) begin
                    errors++;
                    $display("FAIL bist_nominal_vec[m=%0d]: got %0d, want %0d", m, bist_vec, m - 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_bist_ignore_start();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int m = 1; m <= 11; m++) begin
            if (m == 4) bist_start = 1'b1;   // vector 3 on display
            if (m == 5) bist_start = 1'b0;
            checks++;
            if ({bist_busy, bist_done, bist_pass, bist_errs} !== ref_bist(m)) begin
                errors++;
                $display("FAIL bist_ignore_start[m=%0d]: got busy/done/pass/errs=%b, want %b",
                         m, {bist_busy, bist_done, bist_pass, bist_errs}, ref_bist(m));
            end
            if (m <= 8) begin
                checks++;
                if (bist_vec !== 3'(m - 1)) begin
                    errors++;
                    $display("FAIL bist_ignore_vec[m=%0d]: got %0d, want %0d", m, bist_vec, m - 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_bist_reset_abort();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int m = 1; m < 6; m++) tick();   // m = 6 -> vector 5
        checks++;
        if (bist_vec !== 3'd5 || bist_busy !== 1'b1) begin
            errors++;
            $display("FAIL bist_abort_pre: got vec=%0d busy=%b, want 5 1", bist_vec, bist_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bist_busy, bist_done, bist_pass, bist_errs, bist_vec} !== 10'd0) begin
            errors++;
            $display("FAIL bist_abort_now: got busy=%b done=%b pass=%b errs=%0d vec=%0d, want all 0",
                     bist_busy, bist_done, bist_pass, bist_errs, bist_vec);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({bist_busy, bist_done, bist_pass, bist_errs, bist_vec} !== 10'd0) begin
            errors++;
            $display("FAIL bist_abort_idle: got busy=%b done=%b pass=%b errs=%0d vec=%0d, want all 0",
                     bist_busy, bist_done, bist_pass, bist_errs, bist_vec);
        end
    endtask

    task automatic test_bist_independence();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int m = 1; m <= 9; m++) begin
            drive_random();
            #1;
            checks++;
            if ({cout, s} !== ref_add(a, b, cin)) begin
                errors++;
                $display("FAIL indep_comb[m=%0d]: abc=%b%b%b got %b, want %b", m, a, b, cin, {cout, s}, ref_add(a, b, cin));
            end
            if (m == 9) begin
                checks++;
                if ({bist_busy, bist_done, bist_pass, bist_errs} !== ref_bist(m)) begin
                    errors++;
                    $display("FAIL indep_result: got busy/done/pass/errs=%b, want %b",
                             {bist_busy, bist_done, bist_pass, bist_errs}, ref_bist(m));
                end
            end
            else tick();
        end
    endtask

    task automatic test_back_to_back();
        // Start raised in the same cycle reset is released.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bist_start = 1'b1;
        tick();                       // first edge after release samples start
        for (int m = 1; m <= 19; m++) begin
            int phase;
            logic [6:0] want;
            phase = (m - 1) % 9;
            want  = (phase < 8) ? {1'b1, 1'b0, 1'b0, 4'd0} : {1'b0, 1'b1, 1'b1, 4'd0};
            if (m == 19) want = {1'b0, 1'b1, 1'b1, 4'd0};   // start dropped: DONE held
            checks++;
            if ({bist_busy, bist_done, bist_pass, bist_errs} !== want) begin
                errors++;
                $display("FAIL back_to_back[m=%0d]: got busy/done/pass/errs=%b, want %b",
                         m, {bist_busy, bist_done, bist_pass, bist_errs}, want);
            end
            if (phase < 8 && m != 19) begin
                checks++;
                if (bist_vec !== 3'(phase)) begin
                    errors++;
                    $display("FAIL back_to_back_vec[m=%0d]: got %0d, want %0d", m, bist_vec, phase);
                end
            end
            if (m == 18) bist_start = 1'b0;
            tick();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_comb_exhaustive();
        test_comb_random();
        test_registered();
        test_async_reset();
        test_bist_nominal();
        test_bist_ignore_start();
        test_bist_reset_abort();
        test_bist_independence();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
